// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two load/store requesters.
// One grant per cycle, registered one-cycle response pulses, misaligned accesses flagged
// and blocked from writing, saturating contention counter.
module dmem_arbiter #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req0_we,
  input  logic [AW-1:0]    req0_addr,
  input  logic [DW-1:0]    req0_wdata,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [DW-1:0]    rsp0_rdata,
  output logic             rsp0_err,
  input  logic             req1_valid,
  input  logic             req1_we,
  input  logic [AW-1:0]    req1_addr,
  input  logic [DW-1:0]    req1_wdata,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [DW-1:0]    rsp1_rdata,
  output logic             rsp1_err,
  output logic             mem_we,
  output logic [AW-1:0]    mem_a,
  output logic [DW-1:0]    mem_wd,
  input  logic [DW-1:0]    mem_rd,
  output logic [CNT_W-1:0] conflict_cnt
);

  // last_q = 1 means port 1 was granted most recently, so port 0 wins the next contention
  logic             last_q, last_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [DW-1:0]    rsp0_rdata_q, rsp0_rdata_d;
  logic [DW-1:0]    rsp1_rdata_q, rsp1_rdata_d;
  logic             rsp0_err_q, rsp0_err_d;
  logic             rsp1_err_q, rsp1_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic gnt0, gnt1;
  logic mis0, mis1;

  assign mis0 = |req0_addr[1:0];
  assign mis1 = |req1_addr[1:0];

  // Grant decision: single valid wins outright, contention goes to the port not served last
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Memory port mux; port 0 drives address/data when idle, writes only for aligned stores
  always_comb begin
    mem_a  = req0_addr;
    mem_wd = req0_wdata;
    mem_we = gnt0 && req0_we && !mis0;
    if (gnt1) begin
      mem_a  = req1_addr;
      mem_wd = req1_wdata;
      mem_we = req1_we && !mis1;
    end
  end

  // Next-state: capture response of the granted port, pulse valid, count contention
  always_comb begin
    last_d       = last_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    rsp0_err_d   = rsp0_err_q;
    rsp1_err_d   = rsp1_err_q;
    cnt_d        = cnt_q;
    if (gnt0) begin
      last_d       = 1'b0;
      rsp0_valid_d = 1'b1;
      rsp0_err_d   = mis0;
      rsp0_rdata_d = (!req0_we && !mis0) ? mem_rd : '0;
    end
    if (gnt1) begin
      last_d       = 1'b1;
      rsp1_valid_d = 1'b1;
      rsp1_err_d   = mis1;
      rsp1_rdata_d = (!req1_we && !mis1) ? mem_rd : '0;
    end
    if (req0_valid && req1_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q       <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      last_q       <= last_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_err_q   <= rsp1_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp0_rdata   = rsp0_rdata_q;
  assign rsp1_rdata   = rsp1_rdata_q;
  assign rsp0_err     = rsp0_err_q;
  assign rsp1_err     = rsp1_err_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0]    req0_addr = '0;
  logic [DW-1:0]    req0_wdata = '0;
  logic             req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0]    req1_addr = '0;
  logic [DW-1:0]    req1_wdata = '0;
  logic             req0_ready, req1_ready;
  logic             rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [DW-1:0]    rsp0_rdata, rsp1_rdata;
  logic             mem_we;
  logic [AW-1:0]    mem_a;
  logic [DW-1:0]    mem_wd, mem_rd;
  logic [CNT_W-1:0] conflict_cnt;

  logic [31:0] mem [0:63];
  logic        mem_clr = 1'b1;
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: async read, sync write, plus backdoor load and bulk clear
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      if (mem_we) mem[mem_a[7:2]] <= mem_wd;
      if (bd_we) mem[bd_idx] <= bd_data;
    end
  end

  // Requester protocol: a valid request not yet granted must be held unchanged
  logic            pend0 = 1'b0, pend1 = 1'b0;
  logic [AW+DW:0]  hold0, hold1;
  always @(posedge clk) begin
    if (!reset) begin
      if (pend0) assert (req0_valid && ({req0_we, req0_addr, req0_wdata} == hold0))
        else $error("FAIL protocol0: request 0 changed before grant");
      if (pend1) assert (req1_valid && ({req1_we, req1_addr, req1_wdata} == hold1))
        else $error("FAIL protocol1: request 1 changed before grant");
    end
    pend0 <= !reset && req0_valid && !req0_ready;
    pend1 <= !reset && req1_valid && !req1_ready;
    hold0 <= {req0_we, req0_addr, req0_wdata};
    hold1 <= {req1_we, req1_addr, req1_wdata};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [5:0] idx, input logic [31:0] data);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic test_reset;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h0; req0_wdata = 32'hA5A5A5A5;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h4;
    tick();
    mem_clr = 1'b0;
    vectors++; if (req0_ready !== 1'b0) begin miscompares++;
      $display("FAIL rst_ready0: got %b want 0", req0_ready); end
    vectors++; if (req1_ready !== 1'b0) begin miscompares++;
      $display("FAIL rst_ready1: got %b want 0", req1_ready); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++;
      $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    vectors++; if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 4'b0) begin miscompares++;
      $display("FAIL rst_rsp_flags: got %b want 0000",
               {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}); end
    vectors++; if ({rsp0_rdata, rsp1_rdata} !== 64'h0) begin miscompares++;
      $display("FAIL rst_rdata: got %h %h want 0 0", rsp0_rdata, rsp1_rdata); end
    vectors++; if (conflict_cnt !== 16'h0) begin miscompares++;
      $display("FAIL rst_cnt: got %h want 0000", conflict_cnt); end
    req0_valid = 1'b0; req1_valid = 1'b0; req0_we = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_load;
    bd_write(6'd4, 32'hDEADBEEF);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++;
      $display("FAIL load_ready: got %b want 10", {req0_ready, req1_ready}); end
    vectors++; if (mem_a !== 32'h10) begin miscompares++;
      $display("FAIL load_mem_a: got %h want 00000010", mem_a); end
    tick();
    req0_valid = 1'b0;
    vectors++; if ({rsp0_valid, rsp0_err, rsp1_valid} !== 3'b100) begin miscompares++;
      $display("FAIL load_rsp_flags: got %b want 100", {rsp0_valid, rsp0_err, rsp1_valid}); end
    vectors++; if (rsp0_rdata !== 32'hDEADBEEF) begin miscompares++;
      $display("FAIL load_rdata: got %h want deadbeef", rsp0_rdata); end
    tick();
    vectors++; if (rsp0_valid !== 1'b0) begin miscompares++;
      $display("FAIL load_pulse: got %b want 0", rsp0_valid); end
  endtask

  task automatic test_alternate;
    bd_write(6'd8, 32'h00000008);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL alt_grant[%0d]: got %b want %b", i, {req0_ready, req1_ready},
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick();
      vectors++; if ({rsp0_valid, rsp1_valid} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL alt_rsp[%0d]: got %b want %b", i, {rsp0_valid, rsp1_valid},
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
    vectors++; if ({rsp0_rdata, rsp1_rdata} !== {32'hDEADBEEF, 32'h00000008}) begin
      miscompares++;
      $display("FAIL alt_rdata: got %h %h want deadbeef 00000008", rsp0_rdata, rsp1_rdata); end
    vectors++; if (conflict_cnt !== 16'd4) begin miscompares++;
      $display("FAIL alt_cnt: got %0d want 4", conflict_cnt); end
    req1_valid = 1'b0;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin miscompares++;
      $display("FAIL alt_tail_ready0: got %b want 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    vectors++; if (conflict_cnt !== 16'd4) begin miscompares++;
      $display("FAIL alt_cnt_hold: got %0d want 4", conflict_cnt); end
  endtask

  task automatic test_store_load;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h50; req1_wdata = 32'h12345678;
    #1;
    vectors++; if ({req1_ready, mem_we} !== 2'b11 || mem_a !== 32'h50 ||
                   mem_wd !== 32'h12345678) begin
      miscompares++;
      $display("FAIL st_port: got rdy/we %b a %h wd %h want 11 00000050 12345678",
               {req1_ready, mem_we}, mem_a, mem_wd);
    end
    tick();
    req1_valid = 1'b0; req1_we = 1'b0;
    vectors++; if ({rsp1_valid, rsp1_err} !== 2'b10 || rsp1_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL st_rsp: got v/e %b rdata %h want 10 00000000",
               {rsp1_valid, rsp1_err}, rsp1_rdata);
    end
    vectors++; if (mem[20] !== 32'h12345678) begin miscompares++;
      $display("FAIL st_mem: got %h want 12345678", mem[20]); end
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h50;
    tick();
    req0_valid = 1'b0;
    vectors++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h12345678) begin miscompares++;
      $display("FAIL st_ld_rdata: got v %b rdata %h want 1 12345678", rsp0_valid, rsp0_rdata);
    end
  endtask

  task automatic test_misaligned;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h53; req1_wdata = 32'hFFFFFFFF;
    #1;
    vectors++; if ({req1_ready, mem_we} !== 2'b10) begin miscompares++;
      $display("FAIL mis_st_we: got rdy/we %b want 10", {req1_ready, mem_we}); end
    tick();
    req1_valid = 1'b0; req1_we = 1'b0;
    vectors++; if ({rsp1_valid, rsp1_err} !== 2'b11 || rsp1_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL mis_st_rsp: got v/e %b rdata %h want 11 00000000",
               {rsp1_valid, rsp1_err}, rsp1_rdata);
    end
    vectors++; if (mem[20] !== 32'h12345678) begin miscompares++;
      $display("FAIL mis_st_mem: got %h want 12345678", mem[20]); end
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h11;
    tick();
    vectors++; if ({rsp0_valid, rsp0_err} !== 2'b11 || rsp0_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL mis_ld_rsp: got v/e %b rdata %h want 11 00000000",
               {rsp0_valid, rsp0_err}, rsp0_rdata);
    end
    req0_addr = 32'h50;
    tick();
    req0_valid = 1'b0;
    vectors++; if (rsp0_err !== 1'b0 || rsp0_rdata !== 32'h12345678) begin miscompares++;
      $display("FAIL mis_recover: got err %b rdata %h want 0 12345678", rsp0_err, rsp0_rdata);
    end
  endtask

  task automatic test_reset_mid;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
    tick();
    reset = 1'b1;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h20;
    #1;
    vectors++; if ({req0_ready, req1_ready, mem_we} !== 3'b000) begin miscompares++;
      $display("FAIL midrst_grant: got %b want 000", {req0_ready, req1_ready, mem_we}); end
    tick();
    vectors++; if ({rsp0_valid, rsp1_valid} !== 2'b00 || conflict_cnt !== 16'h0 ||
                   rsp0_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_state: got v %b cnt %h rdata %h want 00 0000 00000000",
               {rsp0_valid, rsp1_valid}, conflict_cnt, rsp0_rdata);
    end
    reset = 1'b0;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++;
      $display("FAIL midrst_first: got %b want 10", {req0_ready, req1_ready}); end
    tick();
    vectors++; if (conflict_cnt !== 16'd1) begin miscompares++;
      $display("FAIL midrst_cnt1: got %0d want 1", conflict_cnt); end
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b01) begin miscompares++;
      $display("FAIL midrst_second: got %b want 01", {req0_ready, req1_ready}); end
    tick();
    req1_valid = 1'b0;
    vectors++; if (conflict_cnt !== 16'd2) begin miscompares++;
      $display("FAIL midrst_cnt2: got %0d want 2", conflict_cnt); end
    tick();
    req0_valid = 1'b0;
  endtask

  task automatic test_saturate;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h20;
    repeat (16'hFFFE) @(posedge clk);
    #1;
    vectors++; if (conflict_cnt !== 16'hFFFE) begin miscompares++;
      $display("FAIL sat_pre: got %h want fffe", conflict_cnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (conflict_cnt !== 16'hFFFF) begin miscompares++;
        $display("FAIL sat_hold[%0d]: got %h want ffff", i, conflict_cnt); end
    end
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_alternate();
    test_store_load();
    test_misaligned();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
